// File: rtl/vending_credit_fsm.sv
// -----------------------------------------------------------------------------
// vending_credit_fsm
//
// Credit-and-transaction controller for the vending machine. It accepts coin
// pulses, holds the running credit, serves item selections and pays change
// back one CHANGE_UNIT coin per cycle. Credit is always a multiple of 5 and
// never exceeds MAX_CREDIT, so the two-digit display fed by `value` stays
// within 0..99.
//
// Optional feature macro: VENDING_SALES_COUNT_EN
//   When defined, adds output sales_total[15:0], a saturating running sum of
//   the prices of all dispensed items.
//
// Ports:
//   clk           in   system clock, all logic on posedge
//   rst           in   synchronous reset, active-high
//   coin_5        in   one-cycle pulse, 5-unit coin inserted
//   coin_10       in   one-cycle pulse, 10-unit coin inserted
//   coin_50       in   one-cycle pulse, 50-unit coin inserted
//   sel_a         in   one-cycle pulse, item A requested
//   sel_b         in   one-cycle pulse, item B requested
//   cancel        in   one-cycle pulse, return all credit
//   value         out  [7:0] current credit, to the display stage
//   dispense_a    out  one-cycle pulse, release item A
//   dispense_b    out  one-cycle pulse, release item B
//   change_pulse  out  one-cycle pulse, eject one CHANGE_UNIT coin
//   coin_reject   out  one-cycle pulse, last coin not accepted
//   low_credit    out  one-cycle pulse, selection refused (credit < price)
//   sales_total   out  [15:0] saturating sales sum (VENDING_SALES_COUNT_EN only)
//   busy          out  high while not in IDLE
//
// All outputs are registered: every response appears one cycle after the
// input pulse is sampled.
// -----------------------------------------------------------------------------
module vending_credit_fsm #(
  parameter int unsigned MAX_CREDIT  = 95,
  parameter int unsigned PRICE_A     = 15,
  parameter int unsigned PRICE_B     = 25,
  parameter int unsigned CHANGE_UNIT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coin_5,
  input  logic        coin_10,
  input  logic        coin_50,
  input  logic        sel_a,
  input  logic        sel_b,
  input  logic        cancel,
  output logic [7:0]  value,
  output logic        dispense_a,
  output logic        dispense_b,
  output logic        change_pulse,
  output logic        coin_reject,
  output logic        low_credit,
`ifdef VENDING_SALES_COUNT_EN
  output logic [15:0] sales_total,
`endif
  output logic        busy
);

  // Constants resized once so every comparison below has matching widths.
  localparam logic [8:0] MAX_CREDIT_9 = 9'(MAX_CREDIT);
  localparam logic [7:0] PRICE_A_8    = 8'(PRICE_A);
  localparam logic [7:0] PRICE_B_8    = 8'(PRICE_B);
  localparam logic [7:0] CHANGE_8     = 8'(CHANGE_UNIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  value_r;
  logic [7:0]  value_s;
  logic        dispense_a_s;
  logic        dispense_b_s;
  logic        change_pulse_s;
  logic        coin_reject_s;
  logic        low_credit_s;
  logic        txn_s;          // a cancel or selection was accepted this cycle
  logic [1:0]  coin_count_s;
  logic        coin_any_s;
  logic [8:0]  coin_amt_s;
  logic [8:0]  sum_s;

  // Coin decode: how many coin lines are high and the value of a single coin.
  always_comb begin
    coin_count_s = {1'b0, coin_5} + {1'b0, coin_10} + {1'b0, coin_50};
    coin_any_s   = coin_5 | coin_10 | coin_50;
    if (coin_5) begin
      coin_amt_s = 9'd5;
    end else if (coin_10) begin
      coin_amt_s = 9'd10;
    end else if (coin_50) begin
      coin_amt_s = 9'd50;
    end else begin
      coin_amt_s = 9'd0;
    end
    // 9-bit sum so an overflow past 255 can never alias into a legal value.
    sum_s = {1'b0, value_r} + coin_amt_s;
  end

  // Next-state, next-credit and next-pulse logic.
  always_comb begin
    state_s        = state_r;
    value_s        = value_r;
    dispense_a_s   = 1'b0;
    dispense_b_s   = 1'b0;
    change_pulse_s = 1'b0;
    coin_reject_s  = 1'b0;
    low_credit_s   = 1'b0;
    txn_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Priority cancel > sel_a > sel_b. A refused selection is not a
        // transaction, so a coin in the same cycle is still evaluated.
        // With sel_a and sel_b together, sel_b is never looked at.
        if (cancel && (value_r != 8'd0)) begin
          state_s = ST_CHANGE;
          txn_s   = 1'b1;
        end else if (sel_a) begin
          if (value_r >= PRICE_A_8) begin
            value_s      = value_r - PRICE_A_8;
            dispense_a_s = 1'b1;
            state_s      = ST_VEND;
            txn_s        = 1'b1;
          end else begin
            low_credit_s = 1'b1;
          end
        end else if (sel_b) begin
          if (value_r >= PRICE_B_8) begin
            value_s      = value_r - PRICE_B_8;
            dispense_b_s = 1'b1;
            state_s      = ST_VEND;
            txn_s        = 1'b1;
          end else begin
            low_credit_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end

        if (coin_any_s) begin
          if (txn_s || (coin_count_s != 2'd1) || (sum_s > MAX_CREDIT_9)) begin
            coin_reject_s = 1'b1;
          end else begin
            value_s = sum_s[7:0];
          end
        end else begin
          coin_reject_s = 1'b0;
        end
      end

      ST_VEND: begin
        coin_reject_s = coin_any_s;
        if (value_r != 8'd0) begin
          state_s = ST_CHANGE;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_CHANGE: begin
        coin_reject_s  = coin_any_s;
        change_pulse_s = 1'b1;
        // Clamp at zero so a corrupted credit can never wrap around.
        if (value_r > CHANGE_8) begin
          value_s = value_r - CHANGE_8;
        end else begin
          value_s = 8'd0;
          state_s = ST_IDLE;
        end
      end

      default: begin
        state_s = ST_IDLE;
        value_s = 8'd0;
      end
    endcase
  end

  // State, credit and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      value_r      <= 8'd0;
      dispense_a   <= 1'b0;
      dispense_b   <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      low_credit   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_s;
      value_r      <= value_s;
      dispense_a   <= dispense_a_s;
      dispense_b   <= dispense_b_s;
      change_pulse <= change_pulse_s;
      coin_reject  <= coin_reject_s;
      low_credit   <= low_credit_s;
      busy         <= (state_s != ST_IDLE);
    end
  end

  assign value = value_r;

`ifdef VENDING_SALES_COUNT_EN
  logic [16:0] sales_sum_s;
  logic [15:0] sales_next_s;

  // Saturating sales accumulator, updated on the edge that raises dispense.
  always_comb begin
    if (dispense_a_s) begin
      sales_sum_s = {1'b0, sales_total} + 17'(PRICE_A);
    end else if (dispense_b_s) begin
      sales_sum_s = {1'b0, sales_total} + 17'(PRICE_B);
    end else begin
      sales_sum_s = {1'b0, sales_total};
    end
    if (sales_sum_s[16]) begin
      sales_next_s = 16'hFFFF;
    end else begin
      sales_next_s = sales_sum_s[15:0];
    end
  end

  // Sales total register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sales_total <= 16'd0;
    end else begin
      sales_total <= sales_next_s;
    end
  end
`endif

endmodule

// File: tb/tb_vending_credit_fsm.sv
// -----------------------------------------------------------------------------
// Testbench for vending_credit_fsm: directed test-plan steps followed by
// random pulse traffic, every cycle compared against a behavioural model of
// the credit rules.
// -----------------------------------------------------------------------------
module tb_vending_credit_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, coin_5, coin_10, coin_50, sel_a, sel_b, cancel;
  logic [7:0] value;
  logic       dispense_a, dispense_b, change_pulse, coin_reject, low_credit, busy;
`ifdef VENDING_SALES_COUNT_EN
  logic [15:0] sales_total;
`endif

  vending_credit_fsm dut (
    .clk(clk), .rst(rst), .coin_5(coin_5), .coin_10(coin_10), .coin_50(coin_50),
    .sel_a(sel_a), .sel_b(sel_b), .cancel(cancel), .value(value),
    .dispense_a(dispense_a), .dispense_b(dispense_b), .change_pulse(change_pulse),
    .coin_reject(coin_reject), .low_credit(low_credit),
`ifdef VENDING_SALES_COUNT_EN
    .sales_total(sales_total),
`endif
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: credit as a plain integer, plus the machine's activity.
  int credit;
  int phase;   // 0 waiting for customer, 1 just vended, 2 paying out
  int sales;
  bit e_da, e_db, e_cp, e_rej, e_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit c5, c10, c50, sa, sb, cn, r);
    int  n;
    int  amt;
    bit  taken;
    e_da = 0; e_db = 0; e_cp = 0; e_rej = 0; e_low = 0;
    n = int'(c5) + int'(c10) + int'(c50);
    amt = c5 ? 5 : (c10 ? 10 : (c50 ? 50 : 0));
    taken = 0;
    if (r) begin
      credit = 0; phase = 0; sales = 0;
    end else if (phase == 0) begin
      if (cn && credit > 0) begin
        phase = 2; taken = 1;
      end else if (sa) begin
        if (credit >= 15) begin
          credit -= 15; e_da = 1; phase = 1; taken = 1;
          sales = (sales + 15 > 65535) ? 65535 : sales + 15;
        end else e_low = 1;
      end else if (sb) begin
        if (credit >= 25) begin
          credit -= 25; e_db = 1; phase = 1; taken = 1;
          sales = (sales + 25 > 65535) ? 65535 : sales + 25;
        end else e_low = 1;
      end
      if (n > 0) begin
        if (taken || n > 1 || credit + amt > 95) e_rej = 1;
        else credit += amt;
      end
    end else if (phase == 1) begin
      e_rej = (n > 0);
      phase = (credit > 0) ? 2 : 0;
    end else begin
      e_rej = (n > 0);
      e_cp = 1;
      credit -= 5;
      if (credit == 0) phase = 0;
    end
  endtask

  // One clock: drive inputs on the falling edge, check #1 after the rising edge.
  task automatic step(input bit c5, c10, c50, sa, sb, cn, r);
    @(negedge clk);
    coin_5 = c5; coin_10 = c10; coin_50 = c50;
    sel_a = sa; sel_b = sb; cancel = cn; rst = r;
    @(posedge clk);
    #1;
    model(c5, c10, c50, sa, sb, cn, r);
    chk("value", 32'(value), 32'(credit));
    chk("busy", 32'(busy), 32'(phase != 0));
    chk("dispense_a", 32'(dispense_a), 32'(e_da));
    chk("dispense_b", 32'(dispense_b), 32'(e_db));
    chk("change_pulse", 32'(change_pulse), 32'(e_cp));
    chk("coin_reject", 32'(coin_reject), 32'(e_rej));
    chk("low_credit", 32'(low_credit), 32'(e_low));
`ifdef VENDING_SALES_COUNT_EN
    chk("sales_total", 32'(sales_total), 32'(sales));
`endif
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int pulses;
    int guard;
    rst = 1'b1; coin_5 = 1'b0; coin_10 = 1'b0; coin_50 = 1'b0;
    sel_a = 1'b0; sel_b = 1'b0; cancel = 1'b0;
    credit = 0; phase = 0; sales = 0;

    // Reset state.
    step(0, 0, 0, 0, 0, 0, 1);
    chk("reset_value", 32'(value), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Two 10-unit coins.
    step(0, 1, 0, 0, 0, 0, 0);
    chk("coin10_first", 32'(value), 32'd10);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("coin10_second", 32'(value), 32'd20);
    chk("coin10_no_reject", 32'(coin_reject), 32'd0);

    // sel_b with too little credit.
    step(0, 0, 0, 0, 1, 0, 0);
    chk("selb_low_credit", 32'(low_credit), 32'd1);
    chk("selb_value_kept", 32'(value), 32'd20);

    // sel_a: dispense, VEND, one change pulse, back to idle.
    step(0, 0, 0, 1, 0, 0, 0);
    chk("sela_dispense", 32'(dispense_a), 32'd1);
    chk("sela_value", 32'(value), 32'd5);
    chk("sela_busy", 32'(busy), 32'd1);
    idle();
    idle();
    chk("sela_change_pulse", 32'(change_pulse), 32'd1);
    chk("sela_final_value", 32'(value), 32'd0);
    idle();
    chk("sela_no_more_change", 32'(change_pulse), 32'd0);

    // Overflow and multi-coin rejection at 50.
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("overflow_reject", 32'(coin_reject), 32'd1);
    chk("overflow_value", 32'(value), 32'd50);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("multicoin_reject", 32'(coin_reject), 32'd1);
    chk("multicoin_value", 32'(value), 32'd50);

    // Cancel at 35: seven change pulses, a coin during payout is rejected.
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("cancel_start_value", 32'(value), 32'd35);
    step(0, 0, 0, 0, 0, 1, 0);
    pulses = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 20) begin
      step(guard == 1, 0, 0, 0, 0, 0, 0);
      if (guard == 1) chk("payout_coin_reject", 32'(coin_reject), 32'd1);
      if (change_pulse === 1'b1) pulses++;
      guard++;
    end
    chk("payout_timeout", 32'(busy), 32'd0);
    chk("payout_pulses", 32'(pulses), 32'd7);
    chk("payout_final_value", 32'(value), 32'd0);

    // Reset in the middle of a payout at value 15.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle();
    idle();
    idle();
    chk("midchange_value", 32'(value), 32'd15);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("midreset_value", 32'(value), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    idle();
    chk("midreset_no_pulse", 32'(change_pulse), 32'd0);

    // Random pulse traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
